psum_bram_port_arbiter: RTL and testbench
=========================================

// Module: psum_bram_port_arbiter
// PURPOSE
// - Parametrised successor of the psum BRAM bus mux: shares one psum BRAM port between the host BRAM controller and NUM_PORT core requesters.
// - Ownership follows i_conf_ctrl[0]: 1 = core owns the port, 0 = host owns it. Ownership changes only after in-flight reads drain.
// - Core requesters get round-robin arbitration. Read data is tagged back to its requester with a latency-matched shift register.
// - Sits between dnn_accelerator_core psum ports, the PS BRAM controller and the psum BRAM.
// PARAMETERS
// - NUM_PORT    4   core requester count (1..8)
// - ADDR_WIDTH  32  byte address width
// - DATA_WIDTH  32  data word width
// - NUM_BYTE    4   byte-enable width (DATA_WIDTH/8)
// - REG_WIDTH   32  config register width
// - RD_LATENCY  2   BRAM read latency in cycles, from ena to douta valid (1..4)
// PORTS
// - clk            in   1                     clock
// - rst            in   1                     synchronous reset, active-low
// - i_conf_ctrl    in   REG_WIDTH             bit0 = core-mode request; other bits ignored
// - bram_addr_a    in   ADDR_WIDTH            host address
// - bram_wrdata_a  in   DATA_WIDTH            host write data
// - bram_we_a      in   NUM_BYTE              host byte write enables
// - bram_en_a      in   1                     host access strobe
// - bram_rddata_a  out  DATA_WIDTH            host read data
// - core_req       in   NUM_PORT              per-port request
// - core_we        in   NUM_PORT*NUM_BYTE     per-port byte write enables; all zero = read
// - core_addr      in   NUM_PORT*ADDR_WIDTH   per-port address
// - core_wdat      in   NUM_PORT*DATA_WIDTH   per-port write data
// - core_gnt       out  NUM_PORT              one-hot accept, same cycle as the request is taken
// - core_rvalid    out  NUM_PORT              one-hot read-data valid
// - core_rdat      out  DATA_WIDTH            read data, shared by all ports and qualified by core_rvalid
// - addra          out  ADDR_WIDTH            BRAM address
// - dina           out  DATA_WIDTH            BRAM write data
// - wea            out  NUM_BYTE              BRAM byte write enables
// - ena            out  1                     BRAM enable
// - rsta           out  1                     BRAM output reset, = ~rst
// - douta          in   DATA_WIDTH            BRAM read data
// - o_owner        out  1                     1 = core owns the port
// - o_busy         out  1                     reads in flight, or an ownership switch is pending
// - o_err          out  1                     sticky: host access attempted while core owned the port
// BEHAVIOUR
// - Reset (rst=0 at a clk edge): state HOST.
//   - All outputs 0, except rsta=1.
//   - RR pointer = 0; tag pipe cleared.
// - FSM states: HOST, TO_CORE, CORE, TO_HOST.
//   - HOST -> TO_CORE when ctrl[0]=1.
//   - TO_CORE -> CORE when the tag pipe is empty.
//   - CORE -> TO_HOST when ctrl[0]=0.
//   - TO_HOST -> HOST when the tag pipe is empty.
//   - No new accesses are issued in TO_* states.
//   - A ctrl[0] flip during TO_* reverses the target; the drain rule still applies.
// - BRAM outputs (addra, dina, wea, ena) are registered: issue happens 1 cycle after acceptance.
// - HOST state:
//   - Host signals are passed through that register.
//   - bram_rddata_a = douta.
//   - core_gnt = 0.
// - CORE state:
//   - Pick the first req set at or after the RR pointer. Assert its gnt in that cycle and register its access.
//   - Pointer moves to grant index + 1, wrapping NUM_PORT-1 -> 0.
//   - Throughput: 1 access per cycle.
// - Host access in CORE or TO_* (bram_en_a=1):
//   - The access is dropped; o_err is set (cleared only by reset).
//   - bram_rddata_a = 0.
// - Read tagging:
//   - A core read pushes {valid, port index} into a (1+RD_LATENCY)-deep pipe.
//   - At the pipe output: core_rvalid[idx]=1 and core_rdat = douta.
//   - Writes push valid=0.
//   - Total latency from gnt to rvalid = 1 + RD_LATENCY.
// - Addresses are passed unchanged; no alignment check.
// - Reset mid-operation: in-flight tags are discarded and no rvalid is produced. BRAM contents are untouched.
// STRUCTURE
// - Shared package psum_arb_pkg:
//   - FSM state enum;
//   - OWNER_HOST / OWNER_CORE constants;
//   - CTRL_START_BIT = 0.
// - One sub-module: rr_arbiter (NUM_PORT-wide, returns a one-hot grant and the next pointer).
// - Tag pipe and FSM stay inline.
// TESTING
// - Reset, then host writes 0xDEADBEEF to addr 0x10 and reads it back -> bram_rddata_a = 0xDEADBEEF, RD_LATENCY cycles after issue.
// - ctrl[0]=1; all 4 ports request reads continuously ->
//   - gnt rotates 0,1,2,3,0;
//   - each rvalid arrives 1+RD_LATENCY cycles after its gnt with the correct port's data.
// - Ports 1 and 3 request with the pointer at 2 -> port 3 granted first, then port 1.
// - Core read in flight, then ctrl[0]=0 ->
//   - o_busy=1 until the rvalid is delivered;
//   - o_owner falls only after that;
//   - no core gnt in TO_HOST.
// - In CORE, host bram_en_a=1 with we=0xF ->
//   - BRAM word unchanged;
//   - o_err=1 and stays 1 after returning to HOST.
// - rst=0 for one cycle during a burst of core reads -> no rvalid afterwards; state HOST; all outputs at reset values.

Source files
------------

// File: rtl/psum_arb_pkg.sv
// Shared definitions for the psum BRAM port arbiter: FSM encoding, ownership
// values and the config-register bit that requests core ownership.
package psum_arb_pkg;

    localparam logic [1:0] ST_HOST    = 2'd0;
    localparam logic [1:0] ST_TO_CORE = 2'd1;
    localparam logic [1:0] ST_CORE    = 2'd2;
    localparam logic [1:0] ST_TO_HOST = 2'd3;

    typedef enum logic [1:0] {
        S_HOST    = ST_HOST,
        S_TO_CORE = ST_TO_CORE,
        S_CORE    = ST_CORE,
        S_TO_HOST = ST_TO_HOST
    } arb_state_e;

    localparam logic OWNER_HOST = 1'b0;
    localparam logic OWNER_CORE = 1'b1;

    localparam int unsigned CTRL_START_BIT = 0;

endpackage

// File: rtl/psum_bram_port_arbiter_rr_arbiter.sv
// Round-robin arbiter: grants the first request at or after ptr and returns
// the pointer value that follows the granted index.
module rr_arbiter
    import psum_arb_pkg::*;
#(
    parameter int unsigned NUM_PORT = 4,
    parameter int unsigned PTR_W    = 2
) (
    input  logic [NUM_PORT-1:0] req,
    input  logic [PTR_W-1:0]    ptr,
    output logic [NUM_PORT-1:0] gnt,
    output logic [PTR_W-1:0]    next_ptr
);

    logic found;

    // Two ascending scans: first the indices at or above ptr, then the wrap-around.
    always_comb begin
        gnt      = '0;
        next_ptr = ptr;
        found    = 1'b0;
        for (int unsigned j = 0; j < NUM_PORT; j++) begin
            if (!found && req[j] && (j >= 32'(ptr))) begin
                gnt[j]   = 1'b1;
                found    = 1'b1;
                next_ptr = (j == NUM_PORT - 1) ? '0 : PTR_W'(j + 1);
            end
        end
        for (int unsigned j = 0; j < NUM_PORT; j++) begin
            if (!found && req[j]) begin
                gnt[j]   = 1'b1;
                found    = 1'b1;
                next_ptr = (j == NUM_PORT - 1) ? '0 : PTR_W'(j + 1);
            end
        end
    end

endmodule

// File: rtl/psum_bram_port_arbiter.sv
// Shares one psum BRAM port between the host BRAM controller and NUM_PORT core
// requesters; ownership switches only once in-flight core reads have drained.
module psum_bram_port_arbiter
    import psum_arb_pkg::*;
#(
    parameter int unsigned NUM_PORT   = 4,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_BYTE   = 4,
    parameter int unsigned REG_WIDTH  = 32,
    parameter int unsigned RD_LATENCY = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [REG_WIDTH-1:0]           i_conf_ctrl,
    input  logic [ADDR_WIDTH-1:0]          bram_addr_a,
    input  logic [DATA_WIDTH-1:0]          bram_wrdata_a,
    input  logic [NUM_BYTE-1:0]            bram_we_a,
    input  logic                           bram_en_a,
    output logic [DATA_WIDTH-1:0]          bram_rddata_a,
    input  logic [NUM_PORT-1:0]            core_req,
    input  logic [NUM_PORT*NUM_BYTE-1:0]   core_we,
    input  logic [NUM_PORT*ADDR_WIDTH-1:0] core_addr,
    input  logic [NUM_PORT*DATA_WIDTH-1:0] core_wdat,
    output logic [NUM_PORT-1:0]            core_gnt,
    output logic [NUM_PORT-1:0]            core_rvalid,
    output logic [DATA_WIDTH-1:0]          core_rdat,
    output logic [ADDR_WIDTH-1:0]          addra,
    output logic [DATA_WIDTH-1:0]          dina,
    output logic [NUM_BYTE-1:0]            wea,
    output logic                           ena,
    output logic                           rsta,
    input  logic [DATA_WIDTH-1:0]          douta,
    output logic                           o_owner,
    output logic                           o_busy,
    output logic                           o_err
);

    localparam int unsigned PTR_W = (NUM_PORT > 1) ? $clog2(NUM_PORT) : 1;
    localparam int unsigned DEPTH = 1 + RD_LATENCY;

    arb_state_e              state, state_nxt;
    logic                    owner;
    logic                    err;
    logic [PTR_W-1:0]        rr_ptr, rr_ptr_nxt;
    logic [NUM_PORT-1:0]     arb_req, gnt;
    logic [DEPTH-1:0]        tag_vld;
    logic [PTR_W-1:0]        tag_idx [DEPTH];
    logic                    pipe_busy, ctrl_core;
    logic [PTR_W-1:0]        sel_idx;
    logic [ADDR_WIDTH-1:0]   sel_addr;
    logic [NUM_BYTE-1:0]     sel_we;
    logic [DATA_WIDTH-1:0]   sel_dat;
    logic                    unused_ctrl;

    assign ctrl_core   = i_conf_ctrl[CTRL_START_BIT];
    assign unused_ctrl = ^i_conf_ctrl;
    assign pipe_busy   = |tag_vld;

    // A ctrl flip in a transition state reverses the target; draining still gates arrival.
    always_comb begin
        state_nxt = state;
        case (state)
            S_HOST:    if (ctrl_core) state_nxt = S_TO_CORE;
            S_TO_CORE: if (!ctrl_core) state_nxt = S_TO_HOST;
                       else if (!pipe_busy) state_nxt = S_CORE;
            S_CORE:    if (!ctrl_core) state_nxt = S_TO_HOST;
            S_TO_HOST: if (ctrl_core) state_nxt = S_TO_CORE;
                       else if (!pipe_busy) state_nxt = S_HOST;
            default:   state_nxt = S_HOST;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= S_HOST;
            owner <= OWNER_HOST;
            err   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state_nxt == S_CORE)      owner <= OWNER_CORE;
            else if (state_nxt == S_HOST) owner <= OWNER_HOST;
            if (bram_en_a && (state != S_HOST)) err <= 1'b1;
        end
    end

    assign arb_req = core_req & {NUM_PORT{rst && (state == S_CORE)}};

    rr_arbiter #(
        .NUM_PORT (NUM_PORT),
        .PTR_W    (PTR_W)
    ) u_rr_arbiter (
        .req      (arb_req),
        .ptr      (rr_ptr),
        .gnt      (gnt),
        .next_ptr (rr_ptr_nxt)
    );

    always_comb begin
        sel_idx  = '0;
        sel_addr = '0;
        sel_we   = '0;
        sel_dat  = '0;
        for (int unsigned j = 0; j < NUM_PORT; j++) begin
            if (gnt[j]) begin
                sel_idx  = PTR_W'(j);
                sel_addr = core_addr[j*ADDR_WIDTH +: ADDR_WIDTH];
                sel_we   = core_we[j*NUM_BYTE +: NUM_BYTE];
                sel_dat  = core_wdat[j*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rr_ptr <= '0;
            ena    <= 1'b0;
            wea    <= '0;
            addra  <= '0;
            dina   <= '0;
        end else begin
            if (|gnt) rr_ptr <= rr_ptr_nxt;
            if (state == S_HOST) begin
                ena   <= bram_en_a;
                wea   <= bram_en_a ? bram_we_a : '0;
                addra <= bram_addr_a;
                dina  <= bram_wrdata_a;
            end else if (|gnt) begin
                ena   <= 1'b1;
                wea   <= sel_we;
                addra <= sel_addr;
                dina  <= sel_dat;
            end else begin
                ena   <= 1'b0;
                wea   <= '0;
            end
        end
    end

    // Stage 0 aligns with the registered issue; the last stage lines up with douta.
    always_ff @(posedge clk) begin
        if (!rst) begin
            tag_vld <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) tag_idx[i] <= '0;
        end else begin
            tag_vld    <= {tag_vld[DEPTH-2:0], (|gnt) && !(|sel_we)};
            tag_idx[0] <= sel_idx;
            for (int unsigned i = 1; i < DEPTH; i++) tag_idx[i] <= tag_idx[i-1];
        end
    end

    always_comb begin
        core_rvalid = '0;
        for (int unsigned j = 0; j < NUM_PORT; j++) begin
            core_rvalid[j] = tag_vld[DEPTH-1] && (tag_idx[DEPTH-1] == PTR_W'(j));
        end
    end

    assign core_gnt      = gnt;
    assign core_rdat     = tag_vld[DEPTH-1] ? douta : '0;
    assign bram_rddata_a = (state == S_HOST) ? douta : '0;
    assign rsta          = ~rst;
    assign o_owner       = owner;
    assign o_err         = err;
    assign o_busy        = pipe_busy || (state == S_TO_CORE) || (state == S_TO_HOST);

endmodule

// File: tb/tb_psum_bram_port_arbiter.sv
// Self-checking bench for psum_bram_port_arbiter with a behavioural BRAM model
// and a scoreboard of expected core read returns.
module tb_psum_bram_port_arbiter;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int NB = 4;
    localparam int RW = 32;
    localparam int L  = 2;

    logic            clk;
    logic            rst;
    logic [RW-1:0]   i_conf_ctrl;
    logic [AW-1:0]   bram_addr_a;
    logic [DW-1:0]   bram_wrdata_a;
    logic [NB-1:0]   bram_we_a;
    logic            bram_en_a;
    logic [DW-1:0]   bram_rddata_a;
    logic [N-1:0]    core_req;
    logic [N*NB-1:0] core_we;
    logic [N*AW-1:0] core_addr;
    logic [N*DW-1:0] core_wdat;
    logic [N-1:0]    core_gnt;
    logic [N-1:0]    core_rvalid;
    logic [DW-1:0]   core_rdat;
    logic [AW-1:0]   addra;
    logic [DW-1:0]   dina;
    logic [NB-1:0]   wea;
    logic            ena;
    logic            rsta;
    logic [DW-1:0]   douta;
    logic            o_owner;
    logic            o_busy;
    logic            o_err;

    psum_bram_port_arbiter #(
        .NUM_PORT   (N),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .NUM_BYTE   (NB),
        .REG_WIDTH  (RW),
        .RD_LATENCY (L)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .i_conf_ctrl   (i_conf_ctrl),
        .bram_addr_a   (bram_addr_a),
        .bram_wrdata_a (bram_wrdata_a),
        .bram_we_a     (bram_we_a),
        .bram_en_a     (bram_en_a),
        .bram_rddata_a (bram_rddata_a),
        .core_req      (core_req),
        .core_we       (core_we),
        .core_addr     (core_addr),
        .core_wdat     (core_wdat),
        .core_gnt      (core_gnt),
        .core_rvalid   (core_rvalid),
        .core_rdat     (core_rdat),
        .addra         (addra),
        .dina          (dina),
        .wea           (wea),
        .ena           (ena),
        .rsta          (rsta),
        .douta         (douta),
        .o_owner       (o_owner),
        .o_busy        (o_busy),
        .o_err         (o_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // BRAM model: read-first, L-cycle read latency, output registers cleared by rsta.
    logic [DW-1:0] mem   [256];
    logic [DW-1:0] rpipe [L];
    always @(posedge clk) begin
        if (ena) begin
            rpipe[0] <= mem[addra[9:2]];
            for (int b = 0; b < NB; b++)
                if (wea[b]) mem[addra[9:2]][b*8 +: 8] <= dina[b*8 +: 8];
        end
        for (int k = 1; k < L; k++) rpipe[k] <= rpipe[k-1];
        if (rsta) for (int k = 0; k < L; k++) rpipe[k] <= '0;
    end
    assign douta = rpipe[L-1];

    typedef struct {
        int unsigned   port;
        logic [DW-1:0] data;
        int unsigned   due;
    } exp_t;

    typedef struct {
        logic [N-1:0] req;
        logic [N-1:0] wr;
        logic [N-1:0] gnt;
    } vec_t;

    exp_t          sbq[$];
    vec_t          vecs[14];
    logic [DW-1:0] ref_mem [256];
    int            checks   = 0;
    int            failures = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic set_core(input logic [N-1:0] req, input logic [N-1:0] wr, input logic [DW-1:0] wbase);
        core_req = req;
        for (int p = 0; p < N; p++) begin
            core_addr[p*AW +: AW] = 32'h80 + 32'(4 * p);
            core_we[p*NB +: NB]   = wr[p] ? 4'hF : 4'h0;
            core_wdat[p*DW +: DW] = wbase + 32'(p);
        end
    endtask

    task automatic expect_gnt(input string name, input logic [N-1:0] eg, input logic [N-1:0] wr,
                              input logic [DW-1:0] wbase);
        exp_t e;
        chk(name, core_gnt, eg);
        for (int p = 0; p < N; p++) begin
            if (eg[p]) begin
                if (wr[p]) ref_mem[32 + p] = wbase + 32'(p);
                else begin
                    e.port = p;
                    e.data = ref_mem[32 + p];
                    e.due  = cyc + 1 + L;
                    sbq.push_back(e);
                end
            end
        end
    endtask

    task automatic host_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        bram_en_a = 1'b1; bram_we_a = 4'hF; bram_addr_a = a; bram_wrdata_a = d;
        @(negedge clk);
        bram_en_a = 1'b0; bram_we_a = 4'h0;
        ref_mem[a[9:2]] = d;
    endtask

    task automatic host_read(input logic [AW-1:0] a);
        @(negedge clk);
        bram_en_a = 1'b1; bram_we_a = 4'h0; bram_addr_a = a;
        @(negedge clk);
        bram_en_a = 1'b0;
    endtask

    task automatic wait_owner(input logic want, input string name);
        bit ok = 1'b0;
        for (int k = 0; k < 12 && !ok; k++) begin
            @(negedge clk); #1;
            if (o_owner == want) ok = 1'b1;
        end
        chk(name, o_owner, want);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        bit   done;

        vecs[0]  = '{4'b1111, 4'b0000, 4'b0001};
        vecs[1]  = '{4'b1111, 4'b0000, 4'b0010};
        vecs[2]  = '{4'b1111, 4'b0000, 4'b0100};
        vecs[3]  = '{4'b1111, 4'b0000, 4'b1000};
        vecs[4]  = '{4'b1111, 4'b0000, 4'b0001};
        vecs[5]  = '{4'b0000, 4'b0000, 4'b0000};
        vecs[6]  = '{4'b1010, 4'b0000, 4'b0010};
        vecs[7]  = '{4'b1010, 4'b0000, 4'b1000};
        vecs[8]  = '{4'b1010, 4'b0000, 4'b0010};
        vecs[9]  = '{4'b0001, 4'b0001, 4'b0001};
        vecs[10] = '{4'b1001, 4'b0000, 4'b1000};
        vecs[11] = '{4'b0001, 4'b0000, 4'b0001};
        vecs[12] = '{4'b0100, 4'b0000, 4'b0100};
        vecs[13] = '{4'b0110, 4'b0000, 4'b0010};

        fork
            forever begin
                @(negedge clk);
                if (core_rvalid != '0) begin
                    if (sbq.size() == 0 || sbq[0].due != cyc) begin
                        checks++; failures++;
                        $display("FAIL rvalid_unexpected: got %b expected none (cycle %0d)", core_rvalid, cyc);
                    end else begin
                        e = sbq.pop_front();
                        chk("rvalid_port", core_rvalid, 4'b0001 << e.port);
                        chk("rdat", core_rdat, e.data);
                    end
                end else if (sbq.size() != 0 && sbq[0].due <= cyc) begin
                    e = sbq.pop_front();
                    checks++; failures++;
                    $display("FAIL rvalid_missing: got none expected port %0d (cycle %0d)", e.port, cyc);
                end
            end
        join_none

        rst = 1'b0; i_conf_ctrl = '0;
        bram_addr_a = '0; bram_wrdata_a = '0; bram_we_a = '0; bram_en_a = 1'b0;
        set_core('0, '0, '0);
        repeat (3) @(negedge clk);
        #1;
        chk("reset_outs", {ena, wea, addra, dina, core_gnt, core_rvalid, core_rdat,
                           bram_rddata_a, o_owner, o_busy, o_err}, '0);
        chk("reset_rsta", rsta, 1'b1);

        @(negedge clk); rst = 1'b1;

        host_write(32'h10, 32'hDEADBEEF);
        #1;
        chk("host_wr_issue", {ena, wea, addra, dina}, {1'b1, 4'hF, 32'h10, 32'hDEADBEEF});
        for (int p = 0; p < N; p++) host_write(32'h80 + 32'(4 * p), 32'hA000_0000 + 32'h0101_0101 * 32'(p));

        host_read(32'h10);
        #1;
        chk("host_rd_issue", {ena, wea}, {1'b1, 4'h0});
        repeat (L - 1) @(negedge clk);
        #1;
        checks++;
        if (bram_rddata_a == 32'hDEADBEEF) begin
            failures++;
            $display("FAIL host_rd_early: got %0h one cycle before the read latency elapsed", bram_rddata_a);
        end
        @(negedge clk); #1;
        chk("host_rd_data", bram_rddata_a, 32'hDEADBEEF);

        @(negedge clk); i_conf_ctrl = 32'h1;
        @(negedge clk); #1;
        chk("to_core_busy_owner", {o_busy, o_owner}, 2'b10);
        @(negedge clk); #1;
        chk("core_busy_owner", {o_busy, o_owner}, 2'b01);

        for (int r = 0; r < 14; r++) begin
            @(negedge clk);
            set_core(vecs[r].req, vecs[r].wr, 32'hC0DE_0000 + 32'(16 * r));
            #1;
            expect_gnt($sformatf("table_gnt[%0d]", r), vecs[r].gnt, vecs[r].wr, 32'hC0DE_0000 + 32'(16 * r));
        end
        @(negedge clk); set_core('0, '0, '0);
        done = 1'b0;
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge clk); #1;
            if (sbq.size() == 0) done = 1'b1;
        end
        chk("table_drain", sbq.size(), 0);

        @(negedge clk);
        set_core(4'b0100, '0, '0);
        #1;
        expect_gnt("gnt_before_switch", 4'b0100, '0, '0);
        @(negedge clk); set_core('0, '0, '0); i_conf_ctrl = '0;
        #1;
        chk("owner_still_core", o_owner, 1'b1);
        done = 1'b0;
        for (int k = 0; k < 12 && !done; k++) begin
            @(negedge clk); core_req = 4'hF;
            #1;
            if (o_owner == 1'b0) done = 1'b1;
            else begin
                chk("gnt_in_to_host", core_gnt, 4'b0000);
                chk("busy_in_to_host", o_busy, 1'b1);
            end
        end
        chk("owner_dropped", o_owner, 1'b0);
        chk("rvalid_before_owner_drop", sbq.size(), 0);
        chk("host_state_idle", {core_gnt, o_busy}, '0);
        @(negedge clk); set_core('0, '0, '0);

        i_conf_ctrl = 32'h1;
        wait_owner(1'b1, "owner_core_again");
        @(negedge clk);
        bram_en_a = 1'b1; bram_we_a = 4'hF; bram_addr_a = 32'h10; bram_wrdata_a = 32'h0BADF00D;
        #1;
        chk("host_rdata_blocked", bram_rddata_a, 32'h0);
        @(negedge clk); bram_en_a = 1'b0; bram_we_a = 4'h0;
        #1;
        chk("host_access_dropped", ena, 1'b0);
        chk("err_set", o_err, 1'b1);
        @(negedge clk); i_conf_ctrl = '0;
        wait_owner(1'b0, "owner_host_again");
        chk("err_sticky", o_err, 1'b1);
        chk("bram_word_unchanged", mem[4], 32'hDEADBEEF);
        host_read(32'h10);
        repeat (L) @(negedge clk);
        #1;
        chk("host_rd_after_err", bram_rddata_a, 32'hDEADBEEF);

        @(negedge clk); i_conf_ctrl = 32'h1;
        wait_owner(1'b1, "owner_core_burst");
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); set_core(4'hF, '0, '0);
            #1;
            expect_gnt($sformatf("burst_gnt[%0d]", k), 4'b0001 << ((k + 3) % 4), '0, '0);
        end
        @(negedge clk); rst = 1'b0; i_conf_ctrl = '0;
        #1;
        chk("gnt_in_reset", core_gnt, 4'b0000);
        sbq.delete();
        @(negedge clk); rst = 1'b1; set_core('0, '0, '0);
        #1;
        chk("post_reset_outs", {ena, wea, addra, dina, core_gnt, core_rvalid, core_rdat,
                                bram_rddata_a, o_owner, o_busy, o_err, rsta}, '0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk); #1;
            chk("no_rvalid_after_reset", core_rvalid, 4'b0000);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
